// File: rtl/turfio_cmdproc_buffer.sv
// turfio_cmdproc_buffer
// Packet FIFO behind the command-decoder byte stream. The input side has no
// backpressure, so bytes are written speculatively and a packet only becomes
// readable once its tlast byte is stored. Packets that are aborted, longer
// than MAX_LEN, or that run into a full buffer are discarded whole.
// Committed packets are replayed on an AXI4-Stream master with tready.
//
// Ports:
//   sysclk_i       system clock (single domain)
//   rst_i          synchronous active-high reset
//   cmdproc_rst_i  decoder abort: discard the packet being written
//   s_tdata/s_tvalid/s_tlast  input byte stream, never stalled
//   m_tdata/m_tvalid/m_tready/m_tlast  output stream
//   pkt_count_o    committed packets (wrapping)
//   drop_count_o   dropped packets (saturating at 255)
//   overflow_o     one-cycle pulse per dropped packet
module turfio_cmdproc_buffer #(
  parameter int ADDR_BITS = 8,
  parameter int MAX_LEN   = 64
) (
  input  logic        sysclk_i,
  input  logic        rst_i,
  input  logic        cmdproc_rst_i,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic [15:0] pkt_count_o,
  output logic [7:0]  drop_count_o,
  output logic        overflow_o
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int PW    = ADDR_BITS + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} wstate_t;

  wstate_t state, state_nx;

  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;      // speculative write pointer
  logic [PW-1:0] commit_wr;   // end of last committed packet, write-side view
  logic [PW-1:0] commit_ptr;  // commit_wr one cycle later, the only bound the reader sees
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] len;
  logic [PW-1:0] used;
  logic          full, at_max;
  logic          wr_en, do_commit, do_drop, rewind, rd_en;
  logic [8:0]    rd_word;

  // Occupancy uses the registered rd_ptr, so space freed by a read this
  // cycle only becomes writable on the following cycle.
  assign used   = wr_ptr - rd_ptr;
  assign full   = (used == PW'(DEPTH));
  assign at_max = (len == PW'(MAX_LEN));

  always_comb begin
    state_nx  = state;
    wr_en     = 1'b0;
    do_commit = 1'b0;
    do_drop   = 1'b0;
    rewind    = 1'b0;
    if (cmdproc_rst_i) begin
      // Abort wins over a same-cycle byte; only a packet in progress is a drop.
      state_nx = IDLE;
      rewind   = 1'b1;
      do_drop  = (state == ACTIVE);
    end else if (s_tvalid) begin
      case (state)
        IDLE, ACTIVE: begin
          if (full || at_max) begin
            rewind   = 1'b1;
            do_drop  = 1'b1;
            state_nx = s_tlast ? IDLE : DROP;
          end else begin
            wr_en = 1'b1;
            if (s_tlast) begin
              do_commit = 1'b1;
              state_nx  = IDLE;
            end else begin
              state_nx = ACTIVE;
            end
          end
        end
        DROP:    if (s_tlast) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Write side: FSM, pointers and counters
  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      commit_wr    <= '0;
      commit_ptr   <= '0;
      len          <= '0;
      pkt_count_o  <= '0;
      drop_count_o <= '0;
      overflow_o   <= 1'b0;
    end else begin
      state      <= state_nx;
      overflow_o <= do_drop;
      commit_ptr <= commit_wr;
      if (do_drop && (drop_count_o != 8'hFF)) drop_count_o <= drop_count_o + 8'd1;
      if (rewind) begin
        wr_ptr <= commit_wr;
        len    <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (do_commit) begin
          len         <= '0;
          commit_wr   <= wr_ptr + PW'(1);
          pkt_count_o <= pkt_count_o + 16'd1;
        end else begin
          len <= len + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (wr_en) mem[wr_ptr[ADDR_BITS-1:0]] <= {s_tlast, s_tdata};
  end

  // Read side: single registered output slot
  assign rd_word = mem[rd_ptr[ADDR_BITS-1:0]];
  assign rd_en   = (rd_ptr != commit_ptr) && (!m_tvalid || m_tready);

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
    end else if (rd_en) begin
      rd_ptr   <= rd_ptr + PW'(1);
      m_tvalid <= 1'b1;
      m_tlast  <= rd_word[8];
      m_tdata  <= rd_word[7:0];
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_turfio_cmdproc_buffer.sv
module tb_turfio_cmdproc_buffer;

  localparam int AB    = 8;
  localparam int ML    = 64;
  localparam int DEPTH = 1 << AB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmdproc_rst = 1'b0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [15:0] pkt_count;
  logic [7:0]  drop_count;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  turfio_cmdproc_buffer #(.ADDR_BITS(AB), .MAX_LEN(ML)) dut (
    .sysclk_i(clk), .rst_i(rst), .cmdproc_rst_i(cmdproc_rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .pkt_count_o(pkt_count), .drop_count_o(drop_count), .overflow_o(overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored-but-unread entries; the newest
  // n_unc of them belong to the packet still being written. vis is how many
  // entries at the head the reader may take this cycle.
  logic [8:0]  q[$];
  int          n_unc = 0;
  int          vis = 0;
  int          len = 0;
  bit          dropping = 0;
  bit          mv = 0;
  bit          ml = 0;
  logic [7:0]  md = '0;
  logic [15:0] pkt = '0;
  int          dcnt = 0;
  bit          ovf = 0;

  task automatic m_discard();
    repeat (n_unc) void'(q.pop_back());
    n_unc = 0;
  endtask

  task automatic m_drop();
    if (dcnt < 255) dcnt++;
    ovf = 1;
  endtask

  always @(posedge clk) begin : model
    int c_old;
    bit rd;
    bit full_old;
    if (rst) begin
      q.delete();
      n_unc = 0; vis = 0; len = 0; dropping = 0;
      mv = 0; ml = 0; md = '0; pkt = '0; dcnt = 0; ovf = 0;
    end else begin
      c_old    = q.size() - n_unc;
      full_old = (q.size() == DEPTH);
      rd       = (vis > 0) && (!mv || m_tready);
      ovf      = 0;
      if (rd) begin
        {ml, md} = q.pop_front();
        mv = 1;
      end else if (m_tready) begin
        mv = 0;
      end
      if (cmdproc_rst) begin
        if (len > 0) m_drop();
        m_discard();
        len = 0;
        dropping = 0;
      end else if (s_tvalid) begin
        if (dropping) begin
          if (s_tlast) dropping = 0;
        end else if (full_old || len == ML) begin
          m_drop();
          m_discard();
          len = 0;
          dropping = !s_tlast;
        end else begin
          q.push_back({s_tlast, s_tdata});
          n_unc++;
          len++;
          if (s_tlast) begin
            n_unc = 0;
            len = 0;
            pkt = pkt + 16'd1;
          end
        end
      end
      vis = c_old - (rd ? 1 : 0);
    end
  end

  // Per-cycle comparison plus a log of accepted output bytes
  logic [8:0] outq[$];
  int         ovf_cnt = 0;

  always @(negedge clk) begin
    chk("m_tvalid", m_tvalid, mv);
    chk("m_tdata", m_tdata, md);
    chk("m_tlast", m_tlast, ml);
    chk("pkt_count", pkt_count, pkt);
    chk("drop_count", drop_count, dcnt);
    chk("overflow", overflow, ovf);
    if (rst) begin
      outq.delete();
      ovf_cnt = 0;
    end else begin
      if (m_tvalid && m_tready) outq.push_back({m_tlast, m_tdata});
      if (overflow) ovf_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    cyc();
  endtask

  task automatic idle_in();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] base, input int n, input bit rnd);
    for (int i = 0; i < n; i++)
      send_byte(rnd ? 8'($urandom) : base + 8'(i), (i == n - 1));
    idle_in();
  endtask

  task automatic expect_out(input string nm, input logic [8:0] e[$]);
    chk({nm, "_len"}, outq.size(), e.size());
    for (int i = 0; i < e.size() && i < outq.size(); i++)
      chk($sformatf("%s_b%0d", nm, i), outq[i], e[i]);
  endtask

  initial begin
    logic [8:0] e[$];
    do_reset();
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_drop", drop_count, 0);

    // 1: basic packet and latency
    m_tready = 1'b1;
    send_pkt(8'h11, 4, 0);
    chk("t1_lat_n0", m_tvalid, 0);
    cyc();
    chk("t1_lat_n1", m_tvalid, 0);
    cyc();
    chk("t1_lat_n2", m_tvalid, 1);
    chk("t1_first", m_tdata, 8'h11);
    repeat (8) cyc();
    e = '{9'h011, 9'h012, 9'h013, 9'h114};
    expect_out("t1", e);
    chk("t1_pkt", pkt_count, 1);

    // 2: stalled output, then back-to-back drain
    do_reset();
    m_tready = 1'b0;
    send_pkt(8'hA0, 3, 0);
    send_pkt(8'hB0, 3, 0);
    repeat (14) cyc();
    chk("t2_stall_v", m_tvalid, 1);
    chk("t2_stall_d", m_tdata, 8'hA0);
    m_tready = 1'b1;
    repeat (10) cyc();
    e = '{9'h0A0, 9'h0A1, 9'h1A2, 9'h0B0, 9'h0B1, 9'h1B2};
    expect_out("t2", e);
    chk("t2_pkt", pkt_count, 2);
    chk("t2_drop", drop_count, 0);

    // 3: fill the buffer; the fifth packet runs into full and is dropped
    do_reset();
    m_tready = 1'b0;
    for (int p = 0; p < 4; p++) send_pkt(8'h00, 60, 1);
    send_pkt(8'h00, 30, 1);
    repeat (4) cyc();
    chk("t3_drop", drop_count, 1);
    chk("t3_ovf_pulses", ovf_cnt, 1);
    m_tready = 1'b1;
    repeat (260) cyc();
    chk("t3_out_len", outq.size(), 240);
    chk("t3_pkt", pkt_count, 4);

    // 4: oversized packet
    do_reset();
    m_tready = 1'b1;
    send_pkt(8'h40, 65, 0);
    send_pkt(8'hC0, 2, 0);
    repeat (8) cyc();
    e = '{9'h0C0, 9'h1C1};
    expect_out("t4", e);
    chk("t4_drop", drop_count, 1);
    chk("t4_ovf_pulses", ovf_cnt, 1);
    chk("t4_pkt", pkt_count, 1);

    // 5: decoder abort mid-packet, then abort while idle
    do_reset();
    m_tready = 1'b1;
    send_byte(8'h31, 0);
    send_byte(8'h32, 0);
    send_byte(8'h33, 0);
    cmdproc_rst = 1'b1;
    send_byte(8'h34, 0);
    cmdproc_rst = 1'b0;
    idle_in();
    send_pkt(8'hD0, 2, 0);
    repeat (8) cyc();
    e = '{9'h0D0, 9'h1D1};
    expect_out("t5", e);
    chk("t5_drop", drop_count, 1);
    cmdproc_rst = 1'b1;
    cyc();
    cmdproc_rst = 1'b0;
    repeat (3) cyc();
    chk("t5_idle_abort_drop", drop_count, 1);
    chk("t5_ovf_pulses", ovf_cnt, 1);

    // 6: reset while output is mid-packet
    do_reset();
    m_tready = 1'b0;
    send_pkt(8'h60, 5, 0);
    repeat (3) cyc();
    chk("t6_pre_v", m_tvalid, 1);
    m_tready = 1'b1;
    rst = 1'b1;
    cyc();
    chk("t6_rst_v", m_tvalid, 0);
    chk("t6_rst_pkt", pkt_count, 0);
    rst = 1'b0;
    send_pkt(8'h55, 1, 0);
    repeat (6) cyc();
    e = '{9'h155};
    expect_out("t6", e);

    // Random traffic: slow drain first to exercise full, then fast drain
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      s_tvalid    = ($urandom_range(0, 99) < 75);
      s_tdata     = 8'($urandom);
      s_tlast     = (i % 500 < 450) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 90) == 0);
      cmdproc_rst = ($urandom_range(0, 63) == 0);
      m_tready    = ($urandom_range(0, 99) < ((i < 2000) ? 20 : 85));
      cyc();
    end
    idle_in();
    cmdproc_rst = 1'b0;
    m_tready = 1'b1;
    repeat (300) cyc();
    chk("rnd_drained", m_tvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
